// File: rtl/dmem_rd_pkg.sv
// ----------------------------------------------------------------------------
// dmem_rd_pkg
// Shared types for the data-memory stream reader.
//   state_t      : sequencer states (IDLE, RUN, DRAIN, FIN)
//   DMEM_DEPTH   : number of words in the data memory
//   fifo_entry_t : one buffered output word plus its end-of-burst marker
// ----------------------------------------------------------------------------
package dmem_rd_pkg;

    localparam int DMEM_DEPTH      = 16;
    localparam int DMEM_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    typedef struct packed {
        logic [DMEM_DATA_WIDTH-1:0] data;
        logic                       last;
    } fifo_entry_t;

endpackage

// File: rtl/dmem_rd_fifo.sv
// ----------------------------------------------------------------------------
// dmem_rd_fifo
// Two-entry synchronous FIFO that decouples the memory read sequencer from
// downstream back-pressure.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_entry (caller guarantees count < 2)
//   push_entry  : word and last flag to store
//   pop         : remove the head entry (caller guarantees count != 0)
//   count       : number of stored entries, 0..2
//   head        : oldest stored entry
// ----------------------------------------------------------------------------
module dmem_rd_fifo
    import dmem_rd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t push_entry,
    input  logic        pop,
    output logic [1:0]  count,
    output fifo_entry_t head
);

    fifo_entry_t entries [2];
    logic        wr_ptr;
    logic        rd_ptr;

    // NOTE: the storage is reset along with the pointers; it is only two
    // words, and clearing it makes m_data read as zero straight out of reset.
    // NOTE: every flop here uses <= so all state updates see the values from
    // before the clock edge, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries[0] <= '0;
            entries[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/dmem_stream_reader.sv
// ----------------------------------------------------------------------------
// dmem_stream_reader
// Read-side sequencer for the 16x32 distributed data memory. A command
// (base, len) is turned into a ready/valid word stream by walking the
// memory's asynchronous read port with wrap-around and buffering the words in
// a 2-entry FIFO. A one-cycle done pulse marks completion.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake, ready only in IDLE
//   cmd_base, cmd_len   : first address and word count (0..16, larger saturates)
//   dpra, dpo           : memory read address (registered) and read data
//   m_valid/m_ready     : output stream handshake
//   m_data, m_last      : output word and end-of-burst marker
//   busy                : high whenever not IDLE
//   done                : one-cycle completion pulse
// ----------------------------------------------------------------------------
module dmem_stream_reader
    import dmem_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic [ADDR_WIDTH-1:0] dpra,
    input  logic [DATA_WIDTH-1:0] dpo,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(DMEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   len_sat;
    logic [1:0]            fifo_count;
    fifo_entry_t           head;
    fifo_entry_t           push_entry;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // NOTE: the default assignment comes first so every path through the
    // block drives len_sat and no latch is inferred.
    always_comb begin
        len_sat = cmd_len;
        if (cmd_len > MAX_LEN) begin
            len_sat = MAX_LEN;
        end
    end

    assign accept = cmd_valid && cmd_ready;

    // Push depends only on registered state so m_ready never reaches the
    // memory address or the FIFO write through combinational logic.
    assign push = (state == RUN) && (fifo_count != 2'd2);
    assign pop  = m_valid && m_ready;

    assign push_entry = '{data: dpo, last: (remaining == ONE)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_addr   <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rd_addr   <= cmd_base;
                        remaining <= len_sat;
                        state     <= (cmd_len == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    if (push) begin
                        rd_addr   <= rd_addr + 1'b1;   // wraps 15 -> 0
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Leave once the final buffered word is taken downstream.
                    if ((fifo_count == 2'd0) || (fifo_count == 2'd1 && pop)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs are pure decodes of the state register.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign dpra      = rd_addr;

    dmem_rd_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (fifo_count),
        .head       (head)
    );

    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = head.data;
    assign m_last  = head.last;

endmodule

// File: tb/tb_dmem_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_dmem_stream_reader
// Self-checking bench: a memory array drives dpo from dpra, a behavioural
// model predicts the word stream, busy/ready/done, and stall stability every
// cycle, and directed tests pin latency, wrap, zero length, reset and
// back-to-back command timing with literal values.
// ----------------------------------------------------------------------------
module tb_dmem_stream_reader;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_base;
    logic [4:0]  cmd_len;
    logic [3:0]  dpra;
    logic [31:0] dpo;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;

    logic [31:0] mem [16];
    assign dpo = mem[dpra];

    dmem_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .dpra      (dpra),
        .dpo       (dpo),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: each accepted command expands to its list of
    // words; the stream must deliver exactly that list, then done follows
    // in the next cycle.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q [$];
    bit          busy_exp   = 1'b0;
    bit          done_exp   = 1'b0;
    int          burst_left = 0;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_data;
    logic        stall_last;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            busy_exp   = 1'b0;
            done_exp   = 1'b0;
            burst_left = 0;
            stall_prev = 1'b0;
        end else begin
            bit   next_done;
            bit   next_busy;
            exp_t e;
            next_done = 1'b0;
            next_busy = busy_exp;

            check("busy", busy, busy_exp);
            check("cmd_ready", cmd_ready, !busy_exp);
            check("done", done, done_exp);
            check("fifo_count_le2", u_dut.fifo_count <= 2'd2, 1);
            if (exp_q.size() == 0) check("spurious_valid", m_valid, 0);

            if (stall_prev) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, stall_data);
                check("stall_last", m_last, stall_last);
            end

            if (m_valid && m_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stream_data", m_data, e.data);
                check("stream_last", m_last, e.last);
                burst_left--;
                if (burst_left == 0) next_done = 1'b1;
            end

            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;

            if (cmd_valid && !busy_exp) begin
                int n;
                n = (cmd_len > 5'd16) ? 16 : int'(cmd_len);
                for (int i = 0; i < n; i++) begin
                    exp_t w;
                    w.data = mem[(int'(cmd_base) + i) % 16];
                    w.last = (i == n - 1);
                    exp_q.push_back(w);
                end
                burst_left = n;
                next_busy  = 1'b1;
                if (n == 0) next_done = 1'b1;
            end
            if (done_exp) next_busy = 1'b0;

            busy_exp = next_busy;
            done_exp = next_done;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------

    // Present a command and wait for its acceptance; returns one cycle into
    // the cycle after the accept. done_before reports whether done was high
    // in the cycle just before the accept cycle.
    task automatic issue_cmd(input logic [3:0] b, input logic [4:0] l,
                             input bit hold, output bit done_before);
        bit ok;
        ok          = 1'b0;
        done_before = 1'b0;
        cmd_base    = b;
        cmd_len     = l;
        cmd_valid   = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            else done_before = done;
        end
        if (!ok) check("cmd_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t1_words [4];
    logic [3:0]  wrap_addr [4];

    initial begin
        bit dummy;
        bit db;
        int accepted;

        t1_words[0] = 32'hA000_0002;
        t1_words[1] = 32'hA000_0003;
        t1_words[2] = 32'hA000_0004;
        t1_words[3] = 32'hA000_0005;
        wrap_addr[0] = 4'd14;
        wrap_addr[1] = 4'd15;
        wrap_addr[2] = 4'd0;
        wrap_addr[3] = 4'd1;

        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        m_ready   = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_dpra", dpra, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;

        // base=2, len=4, m_ready=1: latency, data, last, done timing
        issue_cmd(4'd2, 5'd4, 1'b0, dummy);
        @(negedge clk);
        check("t1_no_valid_yet", m_valid, 0);
        check("t1_dpra_first", dpra, 2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_valid", m_valid, 1);
            check("t1_data", m_data, t1_words[k]);
            check("t1_last", m_last, (k == 3));
        end
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_valid_after", m_valid, 0);
        @(negedge clk);
        check("t1_done_clear", done, 0);
        check("t1_ready_back", cmd_ready, 1);
        @(posedge clk);
        #1;

        // base=14, len=4: wrap of the read address
        issue_cmd(4'd14, 5'd4, 1'b0, dummy);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("wrap_dpra", dpra, wrap_addr[k]);
        end
        wait_done(50);

        // base=0, len=16 with m_ready pattern 1,0,0,1
        issue_cmd(4'd0, 5'd16, 1'b0, dummy);
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 300 && !seen; c++) begin
                m_ready = ((c % 4) == 0) || ((c % 4) == 3);
                @(negedge clk);
                if (done) seen = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
            if (!seen) check("stall_burst_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;

        // len=0: done for one cycle, no words
        issue_cmd(4'd5, 5'd0, 1'b0, dummy);
        @(negedge clk);
        check("len0_done", done, 1);
        check("len0_busy", busy, 1);
        check("len0_cmd_ready", cmd_ready, 0);
        check("len0_valid", m_valid, 0);
        @(negedge clk);
        check("len0_done_clear", done, 0);
        check("len0_busy_clear", busy, 0);
        check("len0_cmd_ready_back", cmd_ready, 1);
        @(posedge clk);
        #1;

        // len>16 saturates to a full 16-word pass
        issue_cmd(4'd6, 5'd20, 1'b0, dummy);
        wait_done(100);

        // Reset mid-burst after 5 words, with m_ready low
        issue_cmd(4'd0, 5'd16, 1'b0, dummy);
        accepted = 0;
        for (int i = 0; i < 50 && accepted < 5; i++) begin
            @(negedge clk);
            if (m_valid && m_ready) accepted++;
        end
        check("rst_mid_words_seen", accepted, 5);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", m_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_mid_no_done", done, 0);
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ready = 1'b1;
        issue_cmd(4'd3, 5'd2, 1'b0, dummy);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_word0", m_data, 32'hA000_0003);
        @(negedge clk);
        check("post_rst_word1", m_data, 32'hA000_0004);
        check("post_rst_last", m_last, 1);
        wait_done(20);

        // cmd_valid held high across two back-to-back bursts
        issue_cmd(4'd8, 5'd3, 1'b1, dummy);
        issue_cmd(4'd1, 5'd2, 1'b0, db);
        check("b2b_accept_after_done", db, 1);
        wait_done(50);

        repeat (3) @(posedge clk);
        #1;
        check("end_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
